otter_div_unit: RTL and testbench



---
 rtl/otter_div_unit.sv | 150 +++++++++++++++
 tb/tb_otter_div_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/otter_div_unit.sv
// rtl/otter_div_unit.sv - RV32M multicycle divide/remainder unit (radix-2 restoring, 32 iterations)
module otter_div_unit (
   input  logic        CLK,
   input  logic        RST,
   input  logic        START,
   input  logic [31:0] OP_A,
   input  logic [31:0] OP_B,
   input  logic [1:0]  FUNCT3,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] RESULT
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      PATH_NORM = 2'd0,
      PATH_DZ   = 2'd1,
      PATH_OVF  = 2'd2
   } path_t;

   state_t      state_q, state_d;
   path_t       path_q;
   logic [32:0] rem_q;
   logic [31:0] quo_q;
   logic [31:0] dvsr_q;
   logic [31:0] a_q;
   logic [4:0]  cnt_q;
   logic        want_rem_q;
   logic        neg_q_q;
   logic        neg_r_q;
   logic        done_q;
   logic [31:0] result_q;

   logic        accept;
   logic        is_signed;
   logic        div_zero;
   logic        overflow;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] shifted;
   logic [32:0] trial;
   logic [31:0] quo_fix;
   logic [31:0] rem_fix;
   logic [31:0] fin_value;

   assign accept    = (state_q == IDLE) && START;
   assign is_signed = ~FUNCT3[0];
   assign div_zero  = (OP_B == 32'h0000_0000);
   assign overflow  = is_signed && (OP_A == 32'h8000_0000) && (OP_B == 32'hFFFF_FFFF);
   assign a_mag     = (is_signed && OP_A[31]) ? (32'd0 - OP_A) : OP_A;
   assign b_mag     = (is_signed && OP_B[31]) ? (32'd0 - OP_B) : OP_B;

   // One restoring step: bring the next dividend bit into the partial remainder, then try to subtract.
   assign shifted = {rem_q[31:0], quo_q[31]};
   assign trial   = shifted - {1'b0, dvsr_q};

   assign quo_fix = neg_q_q ? (32'd0 - quo_q) : quo_q;
   assign rem_fix = neg_r_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];

   always_comb begin
      fin_value = want_rem_q ? rem_fix : quo_fix;
      case (path_q)
         PATH_DZ:  fin_value = want_rem_q ? a_q : 32'hFFFF_FFFF;
         PATH_OVF: fin_value = want_rem_q ? 32'h0000_0000 : 32'h8000_0000;
         default:  ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (START) begin
               state_d = (div_zero || overflow) ? FIN : CALC;
            end
         end
         CALC: begin
            if (cnt_q == 5'd0) begin
               state_d = FIN;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         path_q     <= PATH_NORM;
         rem_q      <= 33'd0;
         quo_q      <= 32'd0;
         dvsr_q     <= 32'd0;
         a_q        <= 32'd0;
         cnt_q      <= 5'd0;
         want_rem_q <= 1'b0;
         neg_q_q    <= 1'b0;
         neg_r_q    <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= 32'd0;
      end else begin
         done_q <= (state_q == FIN);
         if (accept) begin
            want_rem_q <= FUNCT3[1];
            neg_q_q    <= is_signed && (OP_A[31] ^ OP_B[31]);
            neg_r_q    <= is_signed && OP_A[31];
            a_q        <= OP_A;
            dvsr_q     <= b_mag;
            rem_q      <= 33'd0;
            quo_q      <= a_mag;
            cnt_q      <= 5'd31;
            if (div_zero) begin
               path_q <= PATH_DZ;
            end else if (overflow) begin
               path_q <= PATH_OVF;
            end else begin
               path_q <= PATH_NORM;
            end
         end else if (state_q == CALC) begin
            cnt_q <= cnt_q - 5'd1;
            if (!trial[32]) begin
               rem_q <= trial;
               quo_q <= {quo_q[30:0], 1'b1};
            end else begin
               rem_q <= shifted;
               quo_q <= {quo_q[30:0], 1'b0};
            end
         end else if (state_q == FIN) begin
            result_q <= fin_value;
         end
      end
   end

   assign BUSY   = (state_q != IDLE);
   assign DONE   = done_q;
   assign RESULT = result_q;

endmodule

// File: tb/tb_otter_div_unit.sv
// tb/tb_otter_div_unit.sv - directed self-checking bench for otter_div_unit
module tb_otter_div_unit;

   logic        CLK;
   logic        RST;
   logic        START;
   logic [31:0] OP_A;
   logic [31:0] OP_B;
   logic [1:0]  FUNCT3;
   logic        BUSY;
   logic        DONE;
   logic [31:0] RESULT;

   int checks;
   int failures;

   localparam logic [1:0] F_DIV  = 2'b00;
   localparam logic [1:0] F_DIVU = 2'b01;
   localparam logic [1:0] F_REM  = 2'b10;
   localparam logic [1:0] F_REMU = 2'b11;

   otter_div_unit dut (
      .CLK    (CLK),
      .RST    (RST),
      .START  (START),
      .OP_A   (OP_A),
      .OP_B   (OP_B),
      .FUNCT3 (FUNCT3),
      .BUSY   (BUSY),
      .DONE   (DONE),
      .RESULT (RESULT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Waits for DONE after the accepting edge; returns edges elapsed and BUSY-high cycles seen.
   task automatic wait_done(output int edges, output int busy_cyc);
      logic seen;
      edges    = 0;
      busy_cyc = 0;
      seen     = 1'b0;
      while (!seen && edges < 40) begin
         if (BUSY) busy_cyc++;
         @(posedge CLK); #1;
         edges++;
         if (DONE) seen = 1'b1;
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int edges;
      int busy_cyc;
      FUNCT3 = f3;
      OP_A   = a;
      OP_B   = b;
      START  = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      wait_done(edges, busy_cyc);
      check({tag, "_latency"}, edges, exp_lat);
      check({tag, "_busy_cycles"}, busy_cyc, exp_lat);
      check({tag, "_busy_at_done"}, {31'd0, BUSY}, 32'd0);
      check({tag, "_result"}, RESULT, exp_res);
   endtask

   initial begin
      int edges;
      int busy_cyc;
      int stray_done;
      checks   = 0;
      failures = 0;
      RST      = 1'b1;
      START    = 1'b0;
      OP_A     = 32'd0;
      OP_B     = 32'd0;
      FUNCT3   = 2'b00;
      repeat (2) @(posedge CLK);
      #1;
      check("reset_busy", {31'd0, BUSY}, 32'd0);
      check("reset_done", {31'd0, DONE}, 32'd0);
      check("reset_result", RESULT, 32'h0000_0000);
      RST = 1'b0;
      @(posedge CLK); #1;

      run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'h0000_000E, 33);
      @(posedge CLK); #1;
      check("done_one_cycle", {31'd0, DONE}, 32'd0);
      check("result_held", RESULT, 32'h0000_000E);

      run_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'h0000_0002, 33);
      run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_op("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_op("rem_7_m2", F_REM, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 33);
      run_op("divu_max_1", F_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
      run_op("div_min_2", F_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);

      run_op("divu_5_0", F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("remu_5_0", F_REMU, 32'd5, 32'd0, 32'h0000_0005, 1);
      run_op("div_m9_0", F_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFFF, 1);
      run_op("rem_m9_0", F_REM, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 1);

      run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
      run_op("divu_ovf_ops", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);

      // Second START plus operand/funct changes mid-calculation must not disturb the op.
      @(posedge CLK); #1;
      FUNCT3 = F_DIVU;
      OP_A   = 32'd100;
      OP_B   = 32'd7;
      START  = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (5) @(posedge CLK);
      #1;
      FUNCT3 = F_REMU;
      OP_A   = 32'd50;
      OP_B   = 32'd0;
      START  = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      wait_done(edges, busy_cyc);
      check("midcalc_latency", edges + 6, 33);
      check("midcalc_result", RESULT, 32'h0000_000E);

      // Back-to-back: new START issued in the DONE cycle of the previous op.
      check("b2b_done_cycle", {31'd0, DONE}, 32'd1);
      run_op("b2b_divu_81_9", F_DIVU, 32'd81, 32'd9, 32'h0000_0009, 33);

      // Reset mid-calculation abandons the op.
      FUNCT3 = F_DIVU;
      OP_A   = 32'd1000;
      OP_B   = 32'd3;
      START  = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
      repeat (10) @(posedge CLK);
      #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      check("rst_mid_busy", {31'd0, BUSY}, 32'd0);
      check("rst_mid_done", {31'd0, DONE}, 32'd0);
      check("rst_mid_result", RESULT, 32'h0000_0000);
      stray_done = 0;
      repeat (40) begin
         @(posedge CLK); #1;
         if (DONE) stray_done++;
      end
      check("rst_no_done", stray_done, 0);
      run_op("post_rst_divu_9_3", F_DIVU, 32'd9, 32'd3, 32'h0000_0003, 33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
